avst_avmm_burst_bridge: RTL and testbench

AVST_AVMM_BURST_BRIDGE -- requirements
Module: avst_avmm_burst_bridge

---
 rtl/avst_avmm_burst_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_avst_avmm_burst_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_avmm_burst_bridge.sv
// rtl/avst_avmm_burst_bridge.sv - AVMM slave to AVST command/response bridge with write-burst unrolling (optional field: AVST_AVMM_BRIDGE_BYTEENABLE_EN)
module avst_avmm_burst_bridge #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 512,
  parameter int BURST_WIDTH    = 4,
  parameter int MAX_RD_PENDING = 64,
`ifdef AVST_AVMM_BRIDGE_BYTEENABLE_EN
  localparam int BE_FIELD_W    = DATA_WIDTH / 8,
`else
  localparam int BE_FIELD_W    = 0,
`endif
  localparam int CMD_WIDTH     = ADDR_WIDTH + DATA_WIDTH + BURST_WIDTH + 2 + BE_FIELD_W,
  localparam int PEND_WIDTH    = $clog2(MAX_RD_PENDING + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     avmm_address,
  input  logic [DATA_WIDTH-1:0]     avmm_writedata,
  input  logic [DATA_WIDTH/8-1:0]   avmm_byteenable,
  input  logic [BURST_WIDTH-1:0]    avmm_burstcount,
  input  logic                      avmm_read,
  input  logic                      avmm_write,
  output logic                      avmm_waitrequest,
  output logic [DATA_WIDTH-1:0]     avmm_readdata,
  output logic                      avmm_readdatavalid,
  output logic [CMD_WIDTH-1:0]      avst_avcmd_data,
  output logic                      avst_avcmd_valid,
  input  logic                      avst_avcmd_ready,
  input  logic [DATA_WIDTH-1:0]     avst_rd_rsp_data,
  input  logic                      avst_rd_rsp_valid,
  output logic                      avst_rd_rsp_ready,
  output logic [PEND_WIDTH-1:0]     rd_pending,
  output logic                      wr_burst_active
);

  localparam int SUM_WIDTH = ((PEND_WIDTH > BURST_WIDTH) ? PEND_WIDTH : BURST_WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE,
    WR_BURST
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BURST_WIDTH-1:0]  beats_left;
  logic [BURST_WIDTH-1:0]  beats_left_next;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [ADDR_WIDTH-1:0]   cap_addr_next;
  logic [BURST_WIDTH-1:0]  cap_burst;
  logic [BURST_WIDTH-1:0]  cap_burst_next;

  logic [1:0]              buf_count;
  logic [CMD_WIDTH-1:0]    buf_head;
  logic [CMD_WIDTH-1:0]    buf_tail;

  logic [BURST_WIDTH-1:0]  burst_eff;
  logic                    rd_req;
  logic                    wr_req;
  logic                    in_burst;
  logic                    pop;
  logic                    space;
  logic [SUM_WIDTH-1:0]    rd_sum;
  logic                    rd_fits;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    push;
  logic                    rsp_dec;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [BURST_WIDTH-1:0]  cmd_burst;
  logic                    cmd_sop;
  logic                    cmd_is_read;
  logic [CMD_WIDTH-1:0]    push_cmd;

  // A zero burstcount is a single beat; read wins when both strobes are high.
  assign burst_eff = (avmm_burstcount == '0) ? BURST_WIDTH'(1) : avmm_burstcount;
  assign rd_req    = avmm_read;
  assign wr_req    = avmm_write & ~avmm_read;
  assign in_burst  = (state == WR_BURST);

  // Space is judged after this cycle's pop so a full buffer can stream.
  assign avst_avcmd_valid = (buf_count != 2'd0);
  assign avst_avcmd_data  = buf_head;
  assign pop              = avst_avcmd_valid & avst_avcmd_ready;
  assign space            = (buf_count != 2'd2) | pop;

  assign rd_sum    = SUM_WIDTH'(rd_pending) + SUM_WIDTH'(burst_eff);
  assign rd_fits   = (rd_sum <= SUM_WIDTH'(MAX_RD_PENDING));
  assign rd_accept = reset_n & rd_req & space & ~in_burst & rd_fits;
  assign wr_accept = reset_n & wr_req & space;
  assign push      = rd_accept | wr_accept;

  assign avmm_waitrequest  = ~reset_n | ~space | (rd_req & (in_burst | ~rd_fits));
  assign avst_rd_rsp_ready = reset_n;
  assign wr_burst_active   = in_burst;

  // Continuation beats of a write burst reuse the captured start address and length.
  always_comb begin
    cmd_addr    = avmm_address;
    cmd_data    = rd_req ? '0 : avmm_writedata;
    cmd_burst   = burst_eff;
    cmd_sop     = 1'b1;
    cmd_is_read = rd_req;
    if (!rd_req && in_burst) begin
      cmd_addr  = cap_addr;
      cmd_burst = cap_burst;
      cmd_sop   = 1'b0;
    end
  end

`ifdef AVST_AVMM_BRIDGE_BYTEENABLE_EN
  logic [DATA_WIDTH/8-1:0] cmd_be;
  assign cmd_be   = rd_req ? {(DATA_WIDTH/8){1'b1}} : avmm_byteenable;
  assign push_cmd = {cmd_addr, cmd_data, cmd_burst, cmd_be, cmd_sop, cmd_is_read};
`else
  logic unused_byteenable;
  assign unused_byteenable = ^avmm_byteenable;
  assign push_cmd = {cmd_addr, cmd_data, cmd_burst, cmd_sop, cmd_is_read};
`endif

  // Two-entry skid buffer; output always comes from the registered head.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_count <= 2'd0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count == 2'd0) buf_head <= push_cmd;
          else                   buf_tail <= push_cmd;
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          buf_head  <= buf_tail;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_head <= push_cmd;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= push_cmd;
          end
        end
        default: ;
      endcase
    end
  end

  // Write FSM state and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      beats_left <= '0;
      cap_addr   <= '0;
      cap_burst  <= '0;
    end else begin
      state      <= state_next;
      beats_left <= beats_left_next;
      cap_addr   <= cap_addr_next;
      cap_burst  <= cap_burst_next;
    end
  end

  // Write FSM next state: open a burst on a multi-beat first beat, count down the rest.
  always_comb begin
    state_next      = state;
    beats_left_next = beats_left;
    cap_addr_next   = cap_addr;
    cap_burst_next  = cap_burst;
    case (state)
      IDLE: begin
        if (wr_accept && (burst_eff > BURST_WIDTH'(1))) begin
          state_next      = WR_BURST;
          beats_left_next = burst_eff - BURST_WIDTH'(1);
          cap_addr_next   = avmm_address;
          cap_burst_next  = burst_eff;
        end
      end
      WR_BURST: begin
        if (wr_accept) begin
          beats_left_next = beats_left - BURST_WIDTH'(1);
          if (beats_left == BURST_WIDTH'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outstanding read beats: add on read accept, retire one per response, never below zero.
  assign rsp_dec = avst_rd_rsp_valid & (rd_pending != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pending <= '0;
    end else begin
      rd_pending <= rd_pending
                  + (rd_accept ? PEND_WIDTH'(burst_eff) : PEND_WIDTH'(0))
                  - PEND_WIDTH'(rsp_dec);
    end
  end

  // Read responses are forwarded one cycle later through a register stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avmm_readdatavalid <= 1'b0;
      avmm_readdata      <= '0;
    end else begin
      avmm_readdatavalid <= avst_rd_rsp_valid;
      if (avst_rd_rsp_valid) avmm_readdata <= avst_rd_rsp_data;
    end
  end

endmodule

// File: tb/tb_avst_avmm_burst_bridge.sv
// tb/tb_avst_avmm_burst_bridge.sv - scoreboard bench for avst_avmm_burst_bridge
module tb_avst_avmm_burst_bridge;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXP = 8;
  localparam int BE_W = DW / 8;
`ifdef AVST_AVMM_BRIDGE_BYTEENABLE_EN
  localparam int CMD_W = AW + DW + BW + 2 + BE_W;
`else
  localparam int CMD_W = AW + DW + BW + 2;
`endif
  localparam int PW = $clog2(MAXP + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     avmm_address = '0;
  logic [DW-1:0]     avmm_writedata = '0;
  logic [BE_W-1:0]   avmm_byteenable = '0;
  logic [BW-1:0]     avmm_burstcount = '0;
  logic              avmm_read = 1'b0;
  logic              avmm_write = 1'b0;
  logic              avmm_waitrequest;
  logic [DW-1:0]     avmm_readdata;
  logic              avmm_readdatavalid;
  logic [CMD_W-1:0]  avst_avcmd_data;
  logic              avst_avcmd_valid;
  logic              avst_avcmd_ready = 1'b0;
  logic [DW-1:0]     avst_rd_rsp_data = '0;
  logic              avst_rd_rsp_valid = 1'b0;
  logic              avst_rd_rsp_ready;
  logic [PW-1:0]     rd_pending;
  logic              wr_burst_active;

  avst_avmm_burst_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_RD_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
    .avmm_byteenable(avmm_byteenable), .avmm_burstcount(avmm_burstcount),
    .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avst_avcmd_data(avst_avcmd_data), .avst_avcmd_valid(avst_avcmd_valid),
    .avst_avcmd_ready(avst_avcmd_ready),
    .avst_rd_rsp_data(avst_rd_rsp_data), .avst_rd_rsp_valid(avst_rd_rsp_valid),
    .avst_rd_rsp_ready(avst_rd_rsp_ready),
    .rd_pending(rd_pending), .wr_burst_active(wr_burst_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  logic [CMD_W-1:0] cmd_q[$];
  rsp_t             rsp_q[$];

  // reference model state
  int            m_pend = 0;
  bit            m_burst = 0;
  int            m_left = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [BW-1:0] cap_bc = '0;
  bit            in_reset = 1'b1;
  int            rdy_pct = 100;
  int            rsp_pct = 0;
  bit            dut_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CMD_W-1:0] pack(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                            input logic [BW-1:0] b, input logic [BE_W-1:0] be,
                                            input logic sop, input logic rd);
`ifdef AVST_AVMM_BRIDGE_BYTEENABLE_EN
    return {a, d, b, be, sop, rd};
`else
    logic unused_be;
    unused_be = ^be;
    return {a, d, b, sop, rd};
`endif
  endfunction

  function automatic bit rv_rand();
    return ($urandom_range(0, 99) < rsp_pct);
  endfunction

  // One bus cycle: drive at negedge, predict and check before the next posedge.
  task automatic cyc_drive(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [BW-1:0] bc, input logic [DW-1:0] wd,
                           input logic [BE_W-1:0] be, input bit rv, output bit acc);
    int  beff;
    bit  space, is_rd, is_wr, exp_wait;
    int  add;
    rsp_t e;
    @(negedge clk);
    avmm_read         = rd;
    avmm_write        = wr;
    avmm_address      = addr;
    avmm_burstcount   = bc;
    avmm_writedata    = wd;
    avmm_byteenable   = be;
    avst_avcmd_ready  = ($urandom_range(0, 99) < rdy_pct);
    avst_rd_rsp_valid = rv;
    avst_rd_rsp_data  = $urandom;
    #2;
    beff     = (bc == 0) ? 1 : int'(bc);
    space    = (cmd_q.size() < 2);
    is_rd    = rd;
    is_wr    = wr && !rd;
    exp_wait = !space || (is_rd && (m_burst || (m_pend + beff > MAXP)));
    dut_wait = avmm_waitrequest;
    chk("waitrequest", 64'(avmm_waitrequest), 64'(exp_wait));
    chk("rd_pending", 64'(rd_pending), 64'(m_pend));
    chk("wr_burst_active", 64'(wr_burst_active), 64'(m_burst));
    chk("rsp_ready", 64'(avst_rd_rsp_ready), 64'd1);
    acc = (is_rd || is_wr) && !exp_wait;
    add = 0;
    if (acc && is_rd) begin
      cmd_q.push_back(pack(addr, '0, BW'(beff), {BE_W{1'b1}}, 1'b1, 1'b1));
      add = beff;
    end else if (acc && is_wr) begin
      if (!m_burst) begin
        cmd_q.push_back(pack(addr, wd, BW'(beff), be, 1'b1, 1'b0));
        if (beff > 1) begin
          m_burst  = 1;
          m_left   = beff - 1;
          cap_addr = addr;
          cap_bc   = BW'(beff);
        end
      end else begin
        cmd_q.push_back(pack(cap_addr, wd, cap_bc, be, 1'b0, 1'b0));
        m_left--;
        if (m_left == 0) m_burst = 0;
      end
    end
    if (rv) begin
      e.d   = avst_rd_rsp_data;
      e.due = cyc + 1;
      rsp_q.push_back(e);
    end
    m_pend = m_pend + add - ((rv && m_pend > 0) ? 1 : 0);
  endtask

  task automatic idle();
    bit acc;
    cyc_drive(0, 0, '0, '0, '0, '0, rv_rand(), acc);
  endtask

  task automatic do_write_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                                input int nsend, input bit try_read);
    bit acc;
    int tries;
    for (int b = 0; b < nsend; b++) begin
      if (try_read && b == 2) cyc_drive(1, 0, $urandom, BW'(1), '0, '0, rv_rand(), acc);
      acc = 0;
      tries = 0;
      while (!acc && tries < 100) begin
        cyc_drive(0, 1, (b == 0) ? addr : AW'($urandom), bc, $urandom, $urandom, rv_rand(), acc);
        tries++;
      end
      if (!acc) chk("write_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [BW-1:0] bc, input bit both);
    bit acc = 0;
    int tries = 0;
    while (!acc && tries < 100) begin
      cyc_drive(1, both, addr, bc, $urandom, $urandom, rv_rand(), acc);
      tries++;
    end
    if (!acc) chk("read_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    in_reset          = 1'b1;
    reset_n           = 1'b0;
    avmm_read         = 1'b0;
    avmm_write        = 1'b0;
    avst_avcmd_ready  = 1'b0;
    avst_rd_rsp_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_waitrequest", 64'(avmm_waitrequest), 64'd1);
      chk("rst_rsp_ready", 64'(avst_rd_rsp_ready), 64'd0);
    end
    chk("rst_cmd_valid", 64'(avst_avcmd_valid), 64'd0);
    chk("rst_rd_pending", 64'(rd_pending), 64'd0);
    chk("rst_wr_burst", 64'(wr_burst_active), 64'd0);
    chk("rst_rdv", 64'(avmm_readdatavalid), 64'd0);
    chk("rst_rdata", 64'(avmm_readdata), 64'd0);
    cmd_q.delete();
    rsp_q.delete();
    m_pend  = 0;
    m_burst = 0;
    m_left  = 0;
    @(negedge clk);
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares command stream and read responses against the scoreboard queues.
  always @(negedge clk) begin
    rsp_t e;
    #1;
    if (!in_reset) begin
      chk("cmd_valid", 64'(avst_avcmd_valid), 64'(cmd_q.size() > 0));
      if (avst_avcmd_valid && cmd_q.size() > 0) begin
        chk("cmd_data", 64'(avst_avcmd_data), 64'(cmd_q[0]));
        if (avst_avcmd_ready) void'(cmd_q.pop_front());
      end
      if (avmm_readdatavalid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_spurious", 64'd1, 64'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_data", 64'(avmm_readdata), 64'(e.d));
          chk("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        chk("rsp_missing", 64'd0, 64'd1);
        void'(rsp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n_acc;
    int tries;
    do_reset(3);

    // single write, then a 4-beat burst with a read attempt mid-burst
    rdy_pct = 100; rsp_pct = 0;
    do_write_burst(16'h1000, 4'd1, 1, 0);
    idle();
    do_write_burst(16'h2000, 4'd4, 4, 1);
    repeat (3) idle();

    // downstream stalled: only two commands fit
    rdy_pct = 0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc_drive(0, 1, AW'(16'h3000 + i), 4'd1, $urandom, $urandom, 0, acc);
      if (!dut_wait) n_acc++;
    end
    chk("stall_accepts", 64'(n_acc), 64'd2);
    rdy_pct = 100;
    repeat (3) idle();

    // read credit limit
    do_read(16'h0100, 4'd4, 0);
    do_read(16'h0200, 4'd4, 0);
    cyc_drive(1, 0, 16'h0300, 4'd4, '0, '0, 0, acc);
    cyc_drive(1, 0, 16'h0300, 4'd4, '0, '0, 1, acc);
    repeat (3) cyc_drive(1, 0, 16'h0300, 4'd4, '0, '0, 1, acc);
    cyc_drive(1, 0, 16'h0300, 4'd4, '0, '0, 0, acc);
    repeat (2) idle();
    // simultaneous read accept (burst 2) and response
    repeat (3) cyc_drive(0, 0, '0, '0, '0, '0, 1, acc);
    cyc_drive(1, 0, 16'h0400, 4'd2, '0, '0, 1, acc);
    repeat (2) idle();

    // reset in the middle of a burst with reads outstanding
    do_write_burst(16'h5000, 4'd4, 2, 0);
    do_reset(2);
    do_write_burst(16'h6000, 4'd1, 1, 0);
    repeat (2) idle();

    // randomized traffic
    rdy_pct = 70; rsp_pct = 40;
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [BW-1:0] bc;
      op = $urandom_range(0, 4);
      if (op <= 1) begin
        bc = BW'($urandom_range(0, 6));
        do_write_burst($urandom, bc, (bc == 0) ? 1 : int'(bc), ($urandom_range(0, 3) == 0));
      end else if (op <= 3) begin
        do_read($urandom, BW'($urandom_range(0, 4)), $urandom_range(0, 1));
      end else begin
        idle();
      end
    end

    // drain everything
    rdy_pct = 100;
    tries = 0;
    while ((m_pend > 0 || cmd_q.size() > 0 || rsp_q.size() > 0) && tries < 300) begin
      cyc_drive(0, 0, '0, '0, '0, '0, (m_pend > 0), acc);
      tries++;
    end
    repeat (2) idle();
    chk("final_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    chk("final_rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
